// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Decode-stage pipeline controller. Produces registered ID/EX
//                control, combinational forwarding selects, load-use stall,
//                branch/jump redirect with flush, a three-state EXEC sequence
//                (IDLE -> WAIT -> RUN) and saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst (async, active-low)
//    instr_vld, opcode[3:0], cond[2:0], flag[2:0] = {N,V,Z}
//    rs_addr, rt_addr, rd_addr         : decode-stage register addresses
//    ex_rd, ex_wen, ex_load            : EX-stage destination info
//    mem_rd, mem_wen                   : MEM-stage destination info
//    alu_op, write_en, mem_enab, mem_write(active-low) : registered ID/EX ctl
//    fwd_rs, fwd_rt                    : 00 regfile, 01 EX, 10 MEM
//    stall, flush, br_taken            : hazard / redirect controls
//    exec_active, exec_ret             : EXEC sequence status / return pulse
//    stall_cnt, flush_cnt              : saturating event counters
// ============================================================================
module pipe_ctrl #(
    parameter int RSIZE    = 4,
    parameter int CNTW     = 16,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_vld,
    input  logic [3:0]       opcode,
    input  logic [2:0]       cond,
    input  logic [2:0]       flag,
    input  logic [RSIZE-1:0] rs_addr,
    input  logic [RSIZE-1:0] rt_addr,
    input  logic [RSIZE-1:0] rd_addr,
    input  logic [RSIZE-1:0] ex_rd,
    input  logic             ex_wen,
    input  logic             ex_load,
    input  logic [RSIZE-1:0] mem_rd,
    input  logic             mem_wen,
    output logic [2:0]       alu_op,
    output logic             write_en,
    output logic             mem_enab,
    output logic             mem_write,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic             stall,
    output logic             flush,
    output logic             br_taken,
    output logic             exec_active,
    output logic             exec_ret,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [2:0]        r_alu_op;
    logic              r_write_en;
    logic              r_mem_enab;
    logic              r_mem_write;
    logic              r_br_taken;
    logic              r_flush;
    logic              r_exec_ret;
    logic [CNTW-1:0]   r_stall_cnt;
    logic [CNTW-1:0]   r_flush_cnt;

    logic [2:0]        w_alu_op;
    logic              w_write_en;
    logic              w_mem_enab;
    logic              w_mem_write;
    logic              w_rs_used;
    logic              w_rt_used;
    logic              w_cond_true;
    logic              w_stall;
    logic              w_issue;
    logic              w_take;
    logic              w_unused;

    // Destination address is consumed by later stages, not by this controller.
    assign w_unused = ^rd_addr;

    // Register address match; address 0 is never a real dependency when it is
    // the hardwired zero register.
    function automatic logic f_match(input logic [RSIZE-1:0] a,
                                     input logic [RSIZE-1:0] b);
        return (a == b) && ((ZERO_REG == 0) || (a != '0));
    endfunction

    always_comb begin
        w_alu_op    = 3'b000;
        w_write_en  = 1'b0;
        w_mem_enab  = 1'b0;
        w_mem_write = 1'b1;
        case (opcode)
            4'd8:  begin w_write_en = 1'b1; w_mem_enab = 1'b1; end
            4'd9:  begin w_mem_enab = 1'b1; w_mem_write = 1'b0; end
            4'd10: w_write_en = 1'b1;
            4'd11: begin w_write_en = 1'b1; w_alu_op = 3'b010; end
            4'd13: w_write_en = 1'b1;
            default: begin
                if (!opcode[3]) begin
                    w_alu_op   = opcode[2:0];
                    w_write_en = 1'b1;
                end
            end
        endcase
    end

    // flag = {N, V, Z}
    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            3'b000:  w_cond_true = flag[0];
            3'b001:  w_cond_true = !flag[0];
            3'b010:  w_cond_true = !flag[0] && !flag[2];
            3'b011:  w_cond_true = flag[2];
            3'b100:  w_cond_true = flag[0] || !flag[2];
            3'b101:  w_cond_true = flag[0] || flag[2];
            3'b110:  w_cond_true = flag[1];
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_rs_used = (opcode < 4'd10) || (opcode == 4'd14);
    assign w_rt_used = (opcode < 4'd4)  || (opcode == 4'd9);

    // A load result is not available from EX, so it is never forwarded from
    // there; the consumer waits one cycle and picks it up from MEM.
    always_comb begin
        fwd_rs = 2'b00;
        if (w_rs_used && ex_wen && !ex_load && f_match(ex_rd, rs_addr))
            fwd_rs = 2'b01;
        else if (mem_wen && f_match(mem_rd, rs_addr))
            fwd_rs = 2'b10;
    end

    always_comb begin
        fwd_rt = 2'b00;
        if (w_rt_used && ex_wen && !ex_load && f_match(ex_rd, rt_addr))
            fwd_rt = 2'b01;
        else if (mem_wen && f_match(mem_rd, rt_addr))
            fwd_rt = 2'b10;
    end

    assign w_stall = instr_vld && ex_load && ex_wen &&
                     ((w_rs_used && f_match(ex_rd, rs_addr)) ||
                      (w_rt_used && f_match(ex_rd, rt_addr)));

    // An instruction issues only when it is valid, not held by a stall, and
    // not the wrong-path slot behind a redirect (flush cycle / WAIT).
    assign w_issue = instr_vld && !w_stall && !r_flush && (r_state != S_WAIT);
    assign w_take  = w_issue && (((opcode == 4'd12) && w_cond_true) ||
                                 (opcode == 4'd13) || (opcode == 4'd14));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_alu_op    <= 3'b000;
            r_write_en  <= 1'b0;
            r_mem_enab  <= 1'b0;
            r_mem_write <= 1'b1;
            r_br_taken  <= 1'b0;
            r_flush     <= 1'b0;
            r_exec_ret  <= 1'b0;
        end else begin
            r_br_taken  <= w_take;
            r_flush     <= w_take;
            r_exec_ret  <= 1'b0;

            // Opcode 15 inside RUN is not allowed to nest; it becomes a bubble.
            if (w_issue && !((r_state == S_RUN) && (opcode == 4'd15))) begin
                r_alu_op    <= w_alu_op;
                r_write_en  <= w_write_en;
                r_mem_enab  <= w_mem_enab;
                r_mem_write <= w_mem_write;
            end else begin
                r_alu_op    <= 3'b000;
                r_write_en  <= 1'b0;
                r_mem_enab  <= 1'b0;
                r_mem_write <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue && (opcode == 4'd15)) begin
                        r_state    <= S_WAIT;
                        r_br_taken <= 1'b1;
                        r_flush    <= 1'b1;
                    end
                end
                S_WAIT: r_state <= S_RUN;
                S_RUN: begin
                    if (!w_stall) begin
                        r_state    <= S_IDLE;
                        // A redirect out of RUN replaces the PC restore.
                        r_exec_ret <= !w_take;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (r_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    assign alu_op      = r_alu_op;
    assign write_en    = r_write_en;
    assign mem_enab    = r_mem_enab;
    assign mem_write   = r_mem_write;
    assign stall       = w_stall;
    assign flush       = r_flush;
    assign br_taken    = r_br_taken;
    assign exec_active = (r_state != S_IDLE);
    assign exec_ret    = r_exec_ret;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire
